// File: rtl/spi_slave_regs_if.sv
// rtl/spi_slave_regs_if.sv - SPI pin bundle between an SPI master and spi_slave_regs
interface spi_slave_regs_if;
   logic spi_SCLK;
   logic spi_MOSI;
   logic spi_SS_n;
   logic spi_MISO;
   logic spi_MISO_oe;

   modport master (
      output spi_SCLK, spi_MOSI, spi_SS_n,
      input  spi_MISO, spi_MISO_oe
   );

   modport slave (
      input  spi_SCLK, spi_MOSI, spi_SS_n,
      output spi_MISO, spi_MISO_oe
   );
endinterface

// File: rtl/spi_slave_regs.sv
// rtl/spi_slave_regs.sv - SPI mode-0 slave onto a 16x8 register file with a local write port
// Optional interrupt output enabled by defining SPI_SLAVE_IRQ_EN.
module spi_slave_regs (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   spi_slave_regs_if.slave  spi,
   input  logic             loc_we,
   input  logic [3:0]       loc_addr,
   input  logic [7:0]       loc_wdata,
   output logic [127:0]     regs_flat,
   output logic             wr_strobe,
   output logic [3:0]       wr_addr,
   output logic [7:0]       wr_data
`ifdef SPI_SLAVE_IRQ_EN
   ,
   output logic             irq_n,
   input  logic             irq_ack
`endif
);

   typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

   state_t      state;
   logic [1:0]  sclk_sync, mosi_sync, ss_sync;
   logic        sclk_prev, ss_prev;
   logic [2:0]  bit_cnt;
   logic [6:0]  rx_shift;
   logic [7:0]  tx_shift;
   logic [3:0]  addr;
   logic        is_write;
   logic [7:0]  regs [16];

   logic        sclk_rise, sclk_fall;
   logic [7:0]  rx_byte;

   assign sclk_rise = sclk_sync[1] & ~sclk_prev;
   assign sclk_fall = ~sclk_sync[1] & sclk_prev;
   assign rx_byte   = {rx_shift, mosi_sync[1]};

   always_comb begin
      regs_flat = '0;
      for (int i = 0; i < 16; i++) begin
         regs_flat[8*i +: 8] = regs[i];
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sclk_sync <= 2'b00;
         mosi_sync <= 2'b00;
         ss_sync   <= 2'b11;
         sclk_prev <= 1'b0;
         ss_prev   <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[0], spi.spi_SCLK};
         mosi_sync <= {mosi_sync[0], spi.spi_MOSI};
         ss_sync   <= {ss_sync[0], spi.spi_SS_n};
         sclk_prev <= sclk_sync[1];
         ss_prev   <= ss_sync[1];
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state           <= IDLE;
         bit_cnt         <= 3'd0;
         rx_shift        <= 7'd0;
         tx_shift        <= 8'd0;
         addr            <= 4'd0;
         is_write        <= 1'b0;
         wr_strobe       <= 1'b0;
         wr_addr         <= 4'd0;
         wr_data         <= 8'd0;
         spi.spi_MISO    <= 1'b0;
         spi.spi_MISO_oe <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            regs[i] <= 8'd0;
         end
      end else begin
         wr_strobe       <= 1'b0;
         spi.spi_MISO_oe <= ~ss_sync[1];
         // Local write first so a same-cycle SPI write to the same address overrides it.
         if (loc_we) begin
            regs[loc_addr] <= loc_wdata;
         end
         if (ss_sync[1]) begin
            state        <= IDLE;
            spi.spi_MISO <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (ss_prev) begin
                     state        <= CMD;
                     bit_cnt      <= 3'd0;
                     spi.spi_MISO <= 1'b0;
                  end
               end
               CMD: begin
                  if (sclk_rise) begin
                     rx_shift <= rx_byte[6:0];
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        state    <= DATA;
                        is_write <= rx_byte[7];
                        if (rx_byte[7]) begin
                           addr <= rx_byte[3:0];
                        end else begin
                           tx_shift <= regs[rx_byte[3:0]];
                           addr     <= rx_byte[3:0] + 4'd1;
                        end
                     end
                  end
               end
               DATA: begin
                  if (sclk_rise) begin
                     rx_shift <= rx_byte[6:0];
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        if (is_write) begin
                           regs[addr] <= rx_byte;
                           wr_strobe  <= 1'b1;
                           wr_addr    <= addr;
                           wr_data    <= rx_byte;
                        end else begin
                           tx_shift <= regs[addr];
                        end
                        addr <= addr + 4'd1;
                     end
                  end else if (sclk_fall) begin
                     if (is_write) begin
                        spi.spi_MISO <= 1'b0;
                     end else begin
                        spi.spi_MISO <= tx_shift[7];
                        tx_shift     <= {tx_shift[6:0], 1'b0};
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef SPI_SLAVE_IRQ_EN
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         irq_n <= 1'b1;
      end else if (wr_strobe) begin
         irq_n <= 1'b0;
      end else if (irq_ack) begin
         irq_n <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_spi_slave_regs.sv
// tb/tb_spi_slave_regs.sv - scoreboard bench for spi_slave_regs driving SPI frames from a bit-banged master
module tb_spi_slave_regs;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         loc_we;
   logic [3:0]   loc_addr;
   logic [7:0]   loc_wdata;
   logic [127:0] regs_flat;
   logic         wr_strobe;
   logic [3:0]   wr_addr;
   logic [7:0]   wr_data;
`ifdef SPI_SLAVE_IRQ_EN
   logic         irq_n;
   logic         irq_ack;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0]  rx_q[$];
   logic [7:0]  exp_miso[$];
   logic [11:0] exp_wr[$];

   spi_slave_regs_if spi_if ();

   spi_slave_regs dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .spi           (spi_if),
      .loc_we        (loc_we),
      .loc_addr      (loc_addr),
      .loc_wdata     (loc_wdata),
      .regs_flat     (regs_flat),
      .wr_strobe     (wr_strobe),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data)
`ifdef SPI_SLAVE_IRQ_EN
      ,
      .irq_n         (irq_n),
      .irq_ack       (irq_ack)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [7:0] reg_at(input int n);
      return regs_flat[8*n +: 8];
   endfunction

   task automatic half();
      repeat (8) @(negedge clk);
   endtask

   // One byte, MSB first; optionally raises loc_we in the exact cycle the SPI write lands.
   task automatic spi_byte(input logic [7:0] b, input int nbits, input logic coll, input logic [3:0] caddr);
      logic [7:0] r;
      r = 8'd0;
      for (int i = 7; i >= 8 - nbits; i--) begin
         spi_if.spi_MOSI = b[i];
         half();
         r = {r[6:0], spi_if.spi_MISO};
         spi_if.spi_SCLK = 1'b1;
         if (coll && i == 0) begin
            @(negedge clk);
            @(negedge clk);
            loc_we    = 1'b1;
            loc_addr  = caddr;
            loc_wdata = 8'hAA;
            @(negedge clk);
            loc_we = 1'b0;
            repeat (5) @(negedge clk);
         end else begin
            half();
         end
         spi_if.spi_SCLK = 1'b0;
      end
      if (nbits == 8) rx_q.push_back(r);
   endtask

   task automatic frame(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input int last_bits, input logic coll, input logic [3:0] caddr);
      logic [7:0] bs [4];
      bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
      spi_if.spi_SS_n = 1'b0;
      half();
      chk("miso_oe_in_frame", spi_if.spi_MISO_oe, 1'b1);
      for (int k = 0; k < n; k++) begin
         spi_byte(bs[k], (k == n - 1) ? last_bits : 8, coll && (k == n - 1), caddr);
      end
      half();
      spi_if.spi_SS_n = 1'b1;
      half();
      half();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_regs"},    regs_flat, 128'd0);
      chk({tag, "_miso"},    spi_if.spi_MISO, 1'b0);
      chk({tag, "_miso_oe"}, spi_if.spi_MISO_oe, 1'b0);
      chk({tag, "_strobe"},  wr_strobe, 1'b0);
      chk({tag, "_wr_addr"}, wr_addr, 4'd0);
      chk({tag, "_wr_data"}, wr_data, 8'd0);
   endtask

   initial begin : miso_monitor
      logic [7:0] got;
      forever begin
         @(negedge clk);
         if (rx_q.size() > 0) begin
            got = rx_q.pop_front();
            if (exp_miso.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL miso_unexpected_byte: got %0h expected none", got);
            end else begin
               chk("miso_byte", got, exp_miso.pop_front());
            end
         end
      end
   end

   initial begin : strobe_monitor
      forever begin
         @(negedge clk);
         if (wr_strobe) begin
            if (exp_wr.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL wr_strobe_unexpected: got addr %0h data %0h expected none", wr_addr, wr_data);
            end else begin
               chk("wr_strobe_addr_data", {wr_addr, wr_data}, exp_wr.pop_front());
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n           = 1'b0;
      spi_if.spi_SCLK = 1'b0;
      spi_if.spi_MOSI = 1'b0;
      spi_if.spi_SS_n = 1'b1;
      loc_we          = 1'b0;
      loc_addr        = 4'd0;
      loc_wdata       = 8'd0;
`ifdef SPI_SLAVE_IRQ_EN
      irq_ack         = 1'b0;
`endif
      repeat (5) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Write 0x5A, 0xC3 starting at address 3
      exp_miso.push_back(8'h00); exp_miso.push_back(8'h00); exp_miso.push_back(8'h00);
      exp_wr.push_back({4'h3, 8'h5A}); exp_wr.push_back({4'h4, 8'hC3});
      frame(3, 8'h83, 8'h5A, 8'hC3, 8'h00, 8, 1'b0, 4'd0);
      chk("reg3_after_write", reg_at(3), 8'h5A);
      chk("reg4_after_write", reg_at(4), 8'hC3);

`ifdef SPI_SLAVE_IRQ_EN
      chk("irq_n_after_write", irq_n, 1'b0);
      irq_ack = 1'b1;
      @(negedge clk);
      irq_ack = 1'b0;
      @(negedge clk);
      chk("irq_n_after_ack", irq_n, 1'b1);
`endif

      // Read back from address 3
      exp_miso.push_back(8'h00); exp_miso.push_back(8'h5A); exp_miso.push_back(8'hC3);
      frame(3, 8'h03, 8'h00, 8'h00, 8'h00, 8, 1'b0, 4'd0);

      // Write burst wrapping 15 -> 0
      exp_miso.push_back(8'h00); exp_miso.push_back(8'h00);
      exp_miso.push_back(8'h00); exp_miso.push_back(8'h00);
      exp_wr.push_back({4'hF, 8'h11}); exp_wr.push_back({4'h0, 8'h22}); exp_wr.push_back({4'h1, 8'h33});
      frame(4, 8'h8F, 8'h11, 8'h22, 8'h33, 8, 1'b0, 4'd0);
      chk("reg15_burst", reg_at(15), 8'h11);
      chk("reg0_burst",  reg_at(0),  8'h22);
      chk("reg1_burst",  reg_at(1),  8'h33);

      // Read burst wrapping 15 -> 0
      exp_miso.push_back(8'h00); exp_miso.push_back(8'h11); exp_miso.push_back(8'h22);
      frame(3, 8'h0F, 8'h00, 8'h00, 8'h00, 8, 1'b0, 4'd0);

      // Partial data byte is discarded
      exp_miso.push_back(8'h00);
      frame(2, 8'h82, 8'hFF, 8'h00, 8'h00, 5, 1'b0, 4'd0);
      chk("reg2_after_partial", reg_at(2), 8'h00);

      // Same-address collision: SPI wins
      exp_miso.push_back(8'h00); exp_miso.push_back(8'h00);
      exp_wr.push_back({4'h2, 8'h55});
      frame(2, 8'h82, 8'h55, 8'h00, 8'h00, 8, 1'b1, 4'd2);
      chk("reg2_collision", reg_at(2), 8'h55);
      chk("reg7_untouched", reg_at(7), 8'h00);

      // Different-address local write in the same cycle lands too
      exp_miso.push_back(8'h00); exp_miso.push_back(8'h00);
      exp_wr.push_back({4'h2, 8'h55});
      frame(2, 8'h82, 8'h55, 8'h00, 8'h00, 8, 1'b1, 4'd7);
      chk("reg2_parallel", reg_at(2), 8'h55);
      chk("reg7_parallel", reg_at(7), 8'hAA);

      // Reset mid-frame
      spi_if.spi_SS_n = 1'b0;
      half();
      spi_byte(8'h83, 4, 1'b0, 4'd0);
      rst_n           = 1'b0;
      spi_if.spi_SS_n = 1'b1;
      spi_if.spi_SCLK = 1'b0;
      spi_if.spi_MOSI = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("mid_reset");
`ifdef SPI_SLAVE_IRQ_EN
      chk("mid_reset_irq_n", irq_n, 1'b1);
`endif
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      exp_miso.push_back(8'h00); exp_miso.push_back(8'h00);
      frame(2, 8'h01, 8'h00, 8'h00, 8'h00, 8, 1'b0, 4'd0);
      chk("regs_after_reset_frame", regs_flat, 128'd0);

      repeat (20) @(negedge clk);
      chk("exp_miso_drained", exp_miso.size(), 0);
      chk("exp_wr_drained", exp_wr.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
